instr_fetch_queue: RTL and testbench

Upstream fetch stage for the encoder/ALU/parity pipeline. A producer writes packed instructions {funccode[7:0], a[3:0], b[3:0]} into a small FIFO. The fetch stage pops them, screens out illegal function codes, and presents one instruction at a time through a registered valid/ready output that feeds the pipeline's funccode/a/b inputs. Only one-hot funccodes reach the encoder.

---
 rtl/instr_fetch_queue.sv | 95 +++++++++
 tb/tb_instr_fetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a FIFO of packed {funccode, a, b} words feeding a registered
// valid/ready output stage that discards entries whose funccode is not one-hot.
module instr_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [15:0]      wr_instr,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       funccode,
  output logic [3:0]       a,
  output logic [3:0]       b,
  output logic [7:0]       illegal_cnt
);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             wr_acc;
  logic             pop;
  logic [15:0]      head;
  logic [7:0]       head_fc;
  logic             head_legal;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_acc  = wr_en && !full && !flush;
  assign pop     = !empty && !flush && (!out_valid || out_ready);
  assign head    = mem[rd_ptr];
  assign head_fc = head[15:8];

  // One-hot test: nonzero and clearing the lowest set bit leaves nothing.
  assign head_legal = (head_fc != 8'd0) && ((head_fc & (head_fc - 8'd1)) == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_instr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      funccode    <= '0;
      a           <= '0;
      b           <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      if (head_legal) begin
        out_valid <= 1'b1;
        funccode  <= head_fc;
        a         <= head[7:4];
        b         <= head[3:0];
      end else begin
        out_valid <= 1'b0;
        if (illegal_cnt != 8'hFF) begin
          illegal_cnt <= illegal_cnt + 8'd1;
        end
      end
    end else if (!out_valid || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed test-plan sequences and random
// traffic, all compared each cycle against a queue-based behavioural model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             wr_en;
  logic [15:0]      wr_instr;
  logic             full;
  logic [PTR_W:0]   count;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       funccode;
  logic [3:0]       a;
  logic [3:0]       b;
  logic [7:0]       illegal_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_q[$];
  logic        m_valid;
  logic [15:0] m_out;
  int          m_ill;
  bit          started = 0;

  logic [15:0] seen[$];

  instr_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_instr(wr_instr),
    .full(full), .count(count), .out_valid(out_valid), .out_ready(out_ready),
    .funccode(funccode), .a(a), .b(b), .illegal_cnt(illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue's contents, the presented word and the illegal tally,
  // advanced from the inputs seen at each rising edge.
  always @(posedge clk) begin
    logic [15:0] h;
    bit          do_pop;
    bit          do_wr;
    if (rst) begin
      m_q.delete();
      m_valid = 1'b0;
      m_out   = '0;
      m_ill   = 0;
      started = 1;
    end else if (flush) begin
      m_q.delete();
      m_valid = 1'b0;
    end else begin
      do_pop = (m_q.size() > 0) && (!m_valid || out_ready);
      do_wr  = wr_en && (m_q.size() < DEPTH);
      if (do_pop) begin
        h = m_q.pop_front();
        if ($countones(h[15:8]) == 1) begin
          m_valid = 1'b1;
          m_out   = h;
        end else begin
          m_valid = 1'b0;
          if (m_ill < 255) m_ill++;
        end
      end else if (!m_valid || out_ready) begin
        m_valid = 1'b0;
      end
      if (do_wr) m_q.push_back(wr_instr);
    end
    #1;
    if (started) begin
      checkOutput("count",       int'(count),       m_q.size());
      checkOutput("full",        int'(full),        int'(m_q.size() == DEPTH));
      checkOutput("out_valid",   int'(out_valid),   int'(m_valid));
      checkOutput("funccode",    int'(funccode),    int'(m_out[15:8]));
      checkOutput("a",           int'(a),           int'(m_out[7:4]));
      checkOutput("b",           int'(b),           int'(m_out[3:0]));
      checkOutput("illegal_cnt", int'(illegal_cnt), m_ill);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] instr,
                               input logic rdy, input logic fl);
    wr_en     = we;
    wr_instr  = instr;
    out_ready = rdy;
    flush     = fl;
    tick();
  endtask

  task automatic recordOut();
    if (out_valid) seen.push_back({funccode, a, b});
  endtask

  logic [7:0]  fcs [8];
  logic [15:0] exp_w;

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_instr = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset funccode", int'(funccode), 0);
    checkOutput("reset illegal_cnt", int'(illegal_cnt), 0);
    checkOutput("reset full", int'(full), 0);

    // Fill with out_ready low: first entry moves to the output register.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, {8'(1 << i), 8'h11}, 1'b0, 1'b0);
    checkOutput("fill count", int'(count), 7);
    checkOutput("fill valid", int'(out_valid), 1);
    checkOutput("fill funccode", int'(funccode), 8'h01);
    applyStimulus(1'b1, 16'h0111, 1'b0, 1'b0);
    checkOutput("9th count", int'(count), 8);
    checkOutput("9th full", int'(full), 1);
    applyStimulus(1'b1, 16'h0999, 1'b0, 1'b0);
    checkOutput("10th dropped count", int'(count), 8);

    // Drain at full rate.
    fcs = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("drain funccode", int'(funccode), int'(fcs[i]));
      checkOutput("drain a", int'(a), 1);
      checkOutput("drain b", int'(b), 1);
      checkOutput("drain count", int'(count), 7 - i);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("drain valid falls", int'(out_valid), 0);

    // Illegal screening.
    seen.delete();
    applyStimulus(1'b1, 16'h0111, 1'b1, 1'b0); recordOut();
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0); recordOut();
    applyStimulus(1'b1, 16'h0311, 1'b1, 1'b0); recordOut();
    applyStimulus(1'b1, 16'h025A, 1'b1, 1'b0); recordOut();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0); recordOut();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0); recordOut();
    checkOutput("screen seen size", seen.size(), 2);
    if (seen.size() == 2) begin
      checkOutput("screen first", int'(seen[0]), 16'h0111);
      checkOutput("screen second", int'(seen[1]), 16'h025A);
    end
    checkOutput("screen illegal_cnt", int'(illegal_cnt), 2);

    // Backpressure hold.
    applyStimulus(1'b1, 16'h0411, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0811, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1011, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("hold funccode", int'(funccode), 8'h04);
      checkOutput("hold valid", int'(out_valid), 1);
      checkOutput("hold count", int'(count), 2);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("release funccode", int'(funccode), 8'h08);
    checkOutput("release count", int'(count), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("release drained", int'(out_valid), 0);

    // Simultaneous write and pop.
    applyStimulus(1'b1, 16'h0111, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0211, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0411, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0811, 1'b0, 1'b0);
    checkOutput("pre-simul count", int'(count), 3);
    applyStimulus(1'b1, 16'h1011, 1'b1, 1'b0);
    checkOutput("simul count", int'(count), 3);
    checkOutput("simul funccode", int'(funccode), 8'h02);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    // Streaming with wrap-around and periodic gaps.
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, {8'(1 << (i % 8)), 4'(i), ~4'(i)}, 1'b1, 1'b0);
      recordOut();
      if (i % 5 == 4) begin
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        recordOut();
      end
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      recordOut();
    end
    checkOutput("stream seen size", seen.size(), 20);
    for (int i = 0; i < 20 && i < seen.size(); i++) begin
      exp_w = {8'(1 << (i % 8)), 4'(i), ~4'(i)};
      checkOutput("stream order", int'(seen[i]), int'(exp_w));
    end

    // Flush keeps illegal_cnt and ignores a same-cycle write.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, {8'(1 << i), 8'h22}, 1'b0, 1'b0);
    checkOutput("preflush count", int'(count), 5);
    checkOutput("preflush valid", int'(out_valid), 1);
    applyStimulus(1'b1, 16'h2011, 1'b0, 1'b1);
    checkOutput("flush count", int'(count), 0);
    checkOutput("flush valid", int'(out_valid), 0);
    checkOutput("flush illegal_cnt", int'(illegal_cnt), 2);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("flush write ignored", int'(out_valid), 0);

    // Saturation of the illegal counter.
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("illegal saturates", int'(illegal_cnt), 255);

    // Random traffic, including occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 1) == 1) ? {8'(1 << $urandom_range(0, 7)), 8'($urandom)}
                                                : 16'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 59) == 0));
    end
    rst = 1'b0;

    // Reset mid-stream.
    applyStimulus(1'b1, 16'h0111, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0211, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0411, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h0811, 1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("midrst count", int'(count), 0);
    checkOutput("midrst valid", int'(out_valid), 0);
    checkOutput("midrst funccode", int'(funccode), 0);
    checkOutput("midrst a", int'(a), 0);
    checkOutput("midrst b", int'(b), 0);
    checkOutput("midrst illegal_cnt", int'(illegal_cnt), 0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
